// File: rtl/trees_pkg.sv
// Shared types and helpers for the trees_lanes tree-ensemble engine:
// node word layout, walker/top state encodings, float ordering and saturation.
package trees_pkg;

    typedef struct packed {
        logic [31:0] value;   // leaf: signed int32 value, internal: float32 threshold
        logic [15:0] right;
        logic [7:0]  feat;
        logic [6:0]  rsvd;
        logic        leaf;
    } node_t;

    typedef enum logic [1:0] {L_IDLE, L_FETCH, L_EVAL, L_NEXT} lane_state_t;
    typedef enum logic [1:0] {T_IDLE, T_RUN, T_SUM} top_state_t;

    // Maps float32 bit patterns onto unsigned integers with the same ordering; both zeros map alike.
    function automatic logic [31:0] flt_ord(input logic [31:0] f);
        if (f[30:0] == 31'd0) return 32'h8000_0000;
        else if (f[31])       return ~f;
        else                  return f | 32'h8000_0000;
    endfunction

    function automatic logic flt_lt(input logic [31:0] a, input logic [31:0] b);
        return flt_ord(a) < flt_ord(b);
    endfunction

    function automatic logic [31:0] sat32(input logic signed [63:0] x);
        if (x > 64'sh0000_0000_7FFF_FFFF)      return 32'h7FFF_FFFF;
        else if (x < -64'sh0000_0000_8000_0000) return 32'h8000_0000;
        else                                    return x[31:0];
    endfunction

endpackage

// File: rtl/trees_lanes_if.sv
// Host load/control/readout bus of trees_lanes.
// cycles_last is present only when TREES_LANES_PERF_EN is defined.
interface trees_lanes_if #(
    parameter int N_TREES          = 128,
    parameter int N_NODE_AND_LEAFS = 256
);
    localparam int TW = $clog2(N_TREES);
    localparam int NW = $clog2(N_NODE_AND_LEAFS);

    logic          start;
    logic [TW:0]   n_trees_active;
    logic          load_trees;
    logic [TW-1:0] n_tree;
    logic [NW-1:0] n_node;
    logic [63:0]   tree_nodes;
    logic          load_features;
    logic [31:0]   n_feature;
    logic [63:0]   features2;
    logic          busy;
    logic [31:0]   prediction;
    logic          done;
    logic          error;
`ifdef TREES_LANES_PERF_EN
    logic [31:0]   cycles_last;

    modport master (output start, n_trees_active, load_trees, n_tree, n_node, tree_nodes,
                           load_features, n_feature, features2,
                    input  busy, prediction, done, error, cycles_last);
    modport slave  (input  start, n_trees_active, load_trees, n_tree, n_node, tree_nodes,
                           load_features, n_feature, features2,
                    output busy, prediction, done, error, cycles_last);
`else
    modport master (output start, n_trees_active, load_trees, n_tree, n_node, tree_nodes,
                           load_features, n_feature, features2,
                    input  busy, prediction, done, error);
    modport slave  (input  start, n_trees_active, load_trees, n_tree, n_node, tree_nodes,
                           load_features, n_feature, features2,
                    output busy, prediction, done, error);
`endif
endinterface

// File: rtl/trees_lane_walker.sv
// One walker lane: private node RAM for trees LANE, LANE+N_LANES, ..., the
// walker FSM, its partial sum and its fault flag.
//   state   | meaning
//   L_IDLE  | finished or waiting for start
//   L_FETCH | RAM read of a child node
//   L_EVAL  | leaf accumulate, or branch / fault decision
//   L_NEXT  | RAM read of the next tree's root
module trees_lane_walker
    import trees_pkg::*;
#(
    parameter int N_TREES          = 128,
    parameter int N_NODE_AND_LEAFS = 256,
    parameter int N_FEATURE        = 32,
    parameter int N_LANES          = 4,
    parameter int MAX_DEPTH        = 16,
    parameter int LANE             = 0
) (
    input  logic                                                    clk,
    input  logic                                                    rst_n,
    input  logic                                                    start_i,
    input  logic [$clog2(N_TREES):0]                                n_act_i,
    input  logic                                                    wr_en_i,
    input  logic [$clog2(N_TREES/N_LANES)+$clog2(N_NODE_AND_LEAFS)-1:0] wr_addr_i,
    input  logic [63:0]                                             wr_data_i,
    input  logic [N_FEATURE-1:0][31:0]                              feat_i,
    output logic                                                    idle_o,
    output logic signed [32+$clog2(N_TREES)-1:0]                    partial_o,
    output logic                                                    fault_o
);
    localparam int ACC_W = 32 + $clog2(N_TREES);
    localparam int NW    = $clog2(N_NODE_AND_LEAFS);
    localparam int N_LOC = N_TREES / N_LANES;
    localparam int LTW   = $clog2(N_LOC);
    localparam int FW    = $clog2(N_FEATURE);
    localparam int DW    = $clog2(MAX_DEPTH);
    localparam logic [DW-1:0] BUDGET_INIT = DW'(MAX_DEPTH - 1);

    lane_state_t              state_q, state_d;
    logic [LTW-1:0]           tree_q, tree_d;
    logic [NW-1:0]            node_q, node_d;
    logic [DW-1:0]            budget_q, budget_d;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic                     fault_q, fault_d;
    logic [63:0]              mem [N_LOC*N_NODE_AND_LEAFS];
    logic [63:0]              rd_q;
    node_t                    nd;
    logic                     more, idx_bad, unused_rsvd;

    always_ff @(posedge clk) begin
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
        if (state_q == L_FETCH || state_q == L_NEXT) rd_q <= mem[{tree_q, node_q}];
    end

    assign nd          = node_t'(rd_q);
    assign unused_rsvd = ^nd.rsvd;
    assign more    = (int'(tree_q) < N_LOC - 1) &&
                     ((int'(tree_q) + 1) * N_LANES + LANE < int'(n_act_i));
    // A left child past the last slot is treated like an out-of-range right child.
    assign idx_bad = (int'(nd.feat) >= N_FEATURE) || (int'(nd.right) >= N_NODE_AND_LEAFS) ||
                     (int'(node_q) == N_NODE_AND_LEAFS - 1);

    always_comb begin
        state_d  = state_q;
        tree_d   = tree_q;
        node_d   = node_q;
        budget_d = budget_q;
        acc_d    = acc_q;
        fault_d  = fault_q;
        unique case (state_q)
            L_IDLE: if (start_i) begin
                acc_d    = '0;
                fault_d  = 1'b0;
                tree_d   = '0;
                node_d   = '0;
                budget_d = BUDGET_INIT;
                if (LANE < int'(n_act_i)) state_d = L_FETCH;
            end
            L_FETCH, L_NEXT: state_d = L_EVAL;
            L_EVAL: begin
                if (!nd.leaf && !idx_bad && budget_q != '0) begin
                    state_d  = L_FETCH;
                    budget_d = budget_q - DW'(1);
                    node_d   = flt_lt(feat_i[nd.feat[FW-1:0]], nd.value) ? node_q + NW'(1)
                                                                          : nd.right[NW-1:0];
                end else begin
                    if (nd.leaf) acc_d = acc_q + $signed({{(ACC_W-32){nd.value[31]}}, nd.value});
                    else         fault_d = 1'b1;
                    if (more) begin
                        state_d  = L_NEXT;
                        tree_d   = tree_q + LTW'(1);
                        node_d   = '0;
                        budget_d = BUDGET_INIT;
                    end else begin
                        state_d  = L_IDLE;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= L_IDLE;
            tree_q   <= '0;
            node_q   <= '0;
            budget_q <= '0;
            acc_q    <= '0;
            fault_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            tree_q   <= tree_d;
            node_q   <= node_d;
            budget_q <= budget_d;
            acc_q    <= acc_d;
            fault_q  <= fault_d;
        end
    end

    assign idle_o    = (state_q == L_IDLE);
    assign partial_o = acc_q;
    assign fault_o   = fault_q;
endmodule

// File: rtl/trees_lanes.sv
// Multi-lane tree-ensemble inference engine with double-buffered feature bank.
// Optional TREES_LANES_PERF_EN adds cycles_last (start-to-done cycle count).
//   state  | meaning
//   T_IDLE | waiting for start; tree loads accepted
//   T_RUN  | lanes walking their trees
//   T_SUM  | combine lane partials, saturate, raise done
module trees_lanes
    import trees_pkg::*;
#(
    parameter int N_TREES          = 128,
    parameter int N_NODE_AND_LEAFS = 256,
    parameter int N_FEATURE        = 32,
    parameter int N_LANES          = 4,
    parameter int MAX_DEPTH        = 16
) (
    input logic           clk,
    input logic           rst_n,
    trees_lanes_if.slave  bus
);
    localparam int TW    = $clog2(N_TREES);
    localparam int NW    = $clog2(N_NODE_AND_LEAFS);
    localparam int LTW   = $clog2(N_TREES / N_LANES);
    localparam int FW    = $clog2(N_FEATURE);
    localparam int ACC_W = 32 + TW;
    localparam logic [TW:0] N_TREES_V = (TW+1)'(N_TREES);

    top_state_t              state_q, state_d;
    logic                    bank_q, bank_d, wr_bank;
    logic [TW:0]             n_act_q, n_act_d, n_in_clamped, n_act_use;
    logic                    done_q, done_d, err_q, err_d;
    logic [31:0]             pred_q, pred_d;
    logic                    start_acc;
    logic [31:0]             feat_mem [2][N_FEATURE];
    logic [N_FEATURE-1:0][31:0] feat_act;
    logic signed [ACC_W-1:0] part [N_LANES];
    logic signed [ACC_W-1:0] total;
    logic [N_LANES-1:0]      lane_idle, lane_fault;
    logic [LTW+NW-1:0]       wr_addr;

    assign start_acc    = bus.start && (state_q == T_IDLE);
    assign n_in_clamped = (int'(bus.n_trees_active) > N_TREES) ? N_TREES_V : bus.n_trees_active;
    assign n_act_use    = start_acc ? n_in_clamped : n_act_q;
    assign wr_addr      = {LTW'(int'(bus.n_tree) / N_LANES), bus.n_node};

    // Writes always target the shadow bank as it stands after any same-cycle swap.
    assign wr_bank = start_acc ? bank_q : ~bank_q;

    always_ff @(posedge clk) begin
        if (bus.load_features && bus.n_feature < 32'(N_FEATURE)) begin
            feat_mem[wr_bank][bus.n_feature[FW-1:0]] <= bus.features2[31:0];
            if (bus.n_feature + 32'd1 < 32'(N_FEATURE))
                feat_mem[wr_bank][bus.n_feature[FW-1:0] + FW'(1)] <= bus.features2[63:32];
        end
    end

    always_comb begin
        for (int i = 0; i < N_FEATURE; i++) feat_act[i] = feat_mem[bank_q][i];
    end

    for (genvar l = 0; l < N_LANES; l++) begin : g_lane
        trees_lane_walker #(
            .N_TREES(N_TREES), .N_NODE_AND_LEAFS(N_NODE_AND_LEAFS), .N_FEATURE(N_FEATURE),
            .N_LANES(N_LANES), .MAX_DEPTH(MAX_DEPTH), .LANE(l)
        ) u_lane (
            .clk       (clk),
            .rst_n     (rst_n),
            .start_i   (start_acc),
            .n_act_i   (n_act_use),
            .wr_en_i   (bus.load_trees && state_q == T_IDLE && (int'(bus.n_tree) % N_LANES == l)),
            .wr_addr_i (wr_addr),
            .wr_data_i (bus.tree_nodes),
            .feat_i    (feat_act),
            .idle_o    (lane_idle[l]),
            .partial_o (part[l]),
            .fault_o   (lane_fault[l])
        );
    end

    always_comb begin
        total = '0;
        for (int l = 0; l < N_LANES; l++) total = total + part[l];
    end

    always_comb begin
        state_d = state_q;
        bank_d  = bank_q;
        n_act_d = n_act_q;
        done_d  = 1'b0;
        err_d   = err_q;
        pred_d  = pred_q;
        unique case (state_q)
            T_IDLE: if (bus.start) begin
                state_d = T_RUN;
                bank_d  = ~bank_q;
                n_act_d = n_in_clamped;
                err_d   = 1'b0;
                pred_d  = '0;
            end
            T_RUN: if (&lane_idle) state_d = T_SUM;
            T_SUM: begin
                state_d = T_IDLE;
                done_d  = 1'b1;
                pred_d  = sat32({{(64-ACC_W){total[ACC_W-1]}}, total});
                err_d   = |lane_fault;
            end
            default: state_d = T_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= T_IDLE;
            bank_q  <= 1'b0;
            n_act_q <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            pred_q  <= '0;
        end else begin
            state_q <= state_d;
            bank_q  <= bank_d;
            n_act_q <= n_act_d;
            done_q  <= done_d;
            err_q   <= err_d;
            pred_q  <= pred_d;
        end
    end

`ifdef TREES_LANES_PERF_EN
    logic [31:0] cyc_q, cyc_d, last_q, last_d;

    always_comb begin
        cyc_d  = cyc_q;
        last_d = last_q;
        if (start_acc)                                  cyc_d = 32'd1;
        else if (state_q != T_IDLE && cyc_q != '1)      cyc_d = cyc_q + 32'd1;
        if (state_q == T_SUM) last_d = (cyc_q == '1) ? cyc_q : cyc_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cyc_q  <= '0;
            last_q <= '0;
        end else begin
            cyc_q  <= cyc_d;
            last_q <= last_d;
        end
    end

    assign bus.cycles_last = last_q;
`endif

    assign bus.busy       = (state_q != T_IDLE);
    assign bus.done       = done_q;
    assign bus.error      = err_q;
    assign bus.prediction = pred_q;
endmodule

// File: tb/tb_trees_lanes.sv
// Directed scoreboard bench for trees_lanes: stimulus pushes expected results,
// a monitor pops and checks them on every done pulse.
module tb_trees_lanes;
    logic clk = 1'b0;
    logic rst_n;
    int   cyc = 0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    trees_lanes_if bus ();
    trees_lanes dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [31:0] p;
        logic        e;
        int          lat;
        int          s;
    } exp_t;

    exp_t q[$];
    int   total = 0;
    int   bad   = 0;
    bit   fin   = 1'b0;

    localparam logic [31:0] F_0_25 = 32'h3E80_0000;
    localparam logic [31:0] F_0_5  = 32'h3F00_0000;
    localparam logic [31:0] F_0_75 = 32'h3F40_0000;

    function automatic logic [63:0] leaf(input logic [31:0] v);
        return {v, 31'd0, 1'b1};
    endfunction

    function automatic logic [63:0] inode(input logic [31:0] thr, input logic [15:0] rc,
                                          input logic [7:0] fi);
        return {thr, rc, fi, 8'd0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_node(input int t, input int n, input logic [63:0] d);
        bus.load_trees = 1'b1;
        bus.n_tree     = 7'(t);
        bus.n_node     = 8'(n);
        bus.tree_nodes = d;
        tick();
        bus.load_trees = 1'b0;
    endtask

    task automatic wr_feat(input int idx, input logic [31:0] f0, input logic [31:0] f1);
        bus.load_features = 1'b1;
        bus.n_feature     = 32'(idx);
        bus.features2     = {f1, f0};
        tick();
        bus.load_features = 1'b0;
    endtask

    task automatic go(input int n, input logic [31:0] p, input logic e, input int lat);
        exp_t x;
        x.p = p; x.e = e; x.lat = lat; x.s = cyc;
        q.push_back(x);
        bus.start          = 1'b1;
        bus.n_trees_active = 8'(n);
        tick();
        bus.start         = 1'b0;
        bus.load_features = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int k = 0;
        while (q.size() != 0 && k < bound) begin
            tick();
            k++;
        end
        if (q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL timeout: %0d results outstanding after %0d cycles, required 0", q.size(), bound);
            q.delete();
        end
        tick();
        tick();
    endtask

    initial begin
        bus.start = 0; bus.n_trees_active = 0; bus.load_trees = 0; bus.n_tree = 0;
        bus.n_node = 0; bus.tree_nodes = 0; bus.load_features = 0; bus.n_feature = 0;
        bus.features2 = 0;
        rst_n = 1'b0;
        fork
            begin : monitor
                while (!fin) begin
                    @(negedge clk);
                    if (rst_n && bus.done) begin
                        if (q.size() == 0) begin
                            total++;
                            bad++;
                            $display("FAIL spurious_done: done at cycle %0d, required none", cyc);
                        end else begin
                            exp_t x;
                            x = q.pop_front();
                            chk("prediction", bus.prediction, x.p);
                            chk("error", {31'd0, bus.error}, {31'd0, x.e});
                            chk("latency", 32'(cyc - x.s), 32'(x.lat));
                        end
                    end
                end
            end
            begin : stimulus
                repeat (3) @(posedge clk);
                #1;
                chk("rst_busy", {31'd0, bus.busy}, 32'd0);
                chk("rst_done", {31'd0, bus.done}, 32'd0);
                chk("rst_error", {31'd0, bus.error}, 32'd0);
                chk("rst_pred", bus.prediction, 32'd0);
                rst_n = 1'b1;
                tick();

                // stumps of value 1
                for (int t = 0; t < 128; t++) wr_node(t, 0, leaf(32'd1));
                go(128, 32'd128, 1'b0, 67);
                tick();
                chk("busy_run", {31'd0, bus.busy}, 32'd1);
                wait_done(200);
                go(0, 32'd0, 1'b0, 3);
                wait_done(20);
                go(200, 32'd128, 1'b0, 67);
                wait_done(200);
                go(5, 32'd5, 1'b0, 7);
                wait_done(20);

                // depth-2 trees, double buffering, same-cycle start+load, dropped writes
                for (int t = 0; t < 128; t++) begin
                    wr_node(t, 0, inode(F_0_5, 16'd2, 8'd3));
                    wr_node(t, 1, leaf(32'd10));
                    wr_node(t, 2, leaf(32'hFFFF_FFF9));
                end
                wr_feat(2, 32'd0, F_0_25);
                go(128, 32'd1280, 1'b0, 131);
                repeat (4) tick();
                bus.start = 1'b1;
                tick();
                bus.start = 1'b0;
                wr_node(0, 1, leaf(32'd1000));
                wr_feat(2, 32'd0, F_0_75);
                wait_done(300);
                bus.load_features = 1'b1;
                bus.n_feature     = 32'd2;
                bus.features2     = {F_0_25, 32'd0};
                go(128, 32'hFFFF_FC80, 1'b0, 131);
                wait_done(300);
                wr_feat(34, F_0_75, F_0_75);
                go(128, 32'd1280, 1'b0, 131);
                wait_done(300);

                // self-loop on every tree -> depth fault
                for (int t = 0; t < 128; t++) wr_node(t, 0, inode(F_0_5, 16'd0, 8'd3));
                wr_feat(2, 32'd0, F_0_75);
                go(128, 32'd0, 1'b1, 1027);
                wait_done(1200);

                // index faults mixed with good leaves, then error clears on next start
                wr_node(0, 0, inode(F_0_5, 16'd2, 8'd40));
                wr_node(1, 0, inode(F_0_5, 16'd300, 8'd3));
                wr_node(2, 0, leaf(32'd5));
                wr_node(3, 0, leaf(32'd6));
                go(4, 32'd11, 1'b1, 5);
                wait_done(20);
                go(0, 32'd0, 1'b0, 3);
                wait_done(20);

                // saturation both directions
                for (int t = 0; t < 128; t++) wr_node(t, 0, leaf(32'h7FFF_FFFF));
                go(128, 32'h7FFF_FFFF, 1'b0, 67);
                wait_done(200);
                for (int t = 0; t < 128; t++) wr_node(t, 0, leaf(32'h8000_0000));
                go(128, 32'h8000_0000, 1'b0, 67);
                wait_done(200);

                // reset mid-run
                go(128, 32'h8000_0000, 1'b0, 67);
                repeat (10) tick();
                rst_n = 1'b0;
                tick();
                tick();
                q.delete();
                rst_n = 1'b1;
                tick();
                chk("abort_busy", {31'd0, bus.busy}, 32'd0);
                chk("abort_done", {31'd0, bus.done}, 32'd0);
                chk("abort_pred", bus.prediction, 32'd0);
                chk("abort_error", {31'd0, bus.error}, 32'd0);
                repeat (80) tick();
                go(128, 32'h8000_0000, 1'b0, 67);
                wait_done(200);
                fin = 1'b1;
            end
        join
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/trees_lanes.md
Name: trees_lanes

Overview:
- Next-generation tree-ensemble inference engine; successor to the single-walker trees block.
- N_LANES walkers traverse disjoint tree subsets in parallel. Lane L owns trees L, L+N_LANES, L+2*N_LANES, ...
- Per-sample feature bank is double-buffered, so host loads sample k+1 while sample k is evaluated.
- Sits between host load/control interface and result readout; one signed prediction per start.

Parameters:
- N_TREES, 128, total tree slots.
- N_NODE_AND_LEAFS, 256, node slots per tree.
- N_FEATURE, 32, float32 features per sample.
- N_LANES, 4, parallel walkers; must divide N_TREES.
- MAX_DEPTH, 16, node visits per tree before abort.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin inference on loaded bank (single-cycle pulse)
- n_trees_active  in  clog2(N_TREES)+1  trees evaluated; latched at start
- load_trees  in  1  node write strobe
- n_tree  in  clog2(N_TREES)  tree index
- n_node  in  clog2(N_NODE_AND_LEAFS)  node index
- tree_nodes  in  64  node word
- load_features  in  1  feature-pair write strobe, always into shadow bank
- n_feature  in  32  even feature index; writes n_feature and n_feature+1
- features2  in  64  [31:0] feature n_feature, [63:32] feature n_feature+1
- busy  out  1  inference in progress
- prediction  out  32  signed saturated ensemble sum
- done  out  1  one-cycle completion pulse
- error  out  1  sticky per inference: depth or index fault

Behaviour:
- Clock and reset: one clock clk; rst_n is asynchronous, active-low.
- Reset values: busy=0, done=0, error=0, prediction=0, bank select=0, FSM=IDLE. Memory contents are not cleared.
- Node format:
  - bit0 = leaf flag.
  - Leaf: [63:32] signed int32 value.
  - Internal: [63:32] float32 threshold; [15:8] feature index; [31:16] right-child node index. Left child = current+1.
- Branch rule: go left if feature < threshold. Float compare uses sign-magnitude to ordered-integer transform; -0 equals +0; NaN not supported.
- Top FSM: IDLE -> RUN on start when !busy.
  - On start: swap feature banks, latch n_trees_active, clear accumulator and error, busy=1.
  - RUN -> SUM when all lanes finish. SUM is 1 cycle: sum lane partials, saturate.
  - SUM -> IDLE: done=1 for 1 cycle, busy=0.
- Lane FSM: IDLE, FETCH (synchronous RAM read, 1 cycle), EVAL (leaf or branch), NEXT (advance tree). 2 cycles per visited node.
- Lane tree selection: lane evaluates tree t if t < n_trees_active; otherwise the lane finishes immediately.
- Accumulator width 32+clog2(N_TREES) per lane and total. prediction saturates to [-2^31, 2^31-1].
- Latency for depth d trees: 2 + sum over lane of 2*(visits) + 1 cycles.
- Boundary conditions:
  - n_trees_active=0: done exactly 3 cycles after start, prediction=0.
  - n_trees_active > N_TREES: clamped to N_TREES.
  - Depth fault: visits reach MAX_DEPTH without a leaf. That tree contributes 0 and error=1.
  - Index fault: feature index >= N_FEATURE, or right child >= N_NODE_AND_LEAFS. That tree contributes 0 and error=1.
  - start while busy: ignored.
  - load_trees while busy: write dropped.
  - load_features while busy: accepted into shadow bank.
  - load_features with n_feature >= N_FEATURE: dropped.
  - start and load_features in the same cycle: the write lands in the new shadow bank, i.e. after the swap.
  - rst_n low mid-inference: abort immediately, no done pulse, outputs to reset values.
- prediction and error hold until the next accepted start.

Optional Feature:
- Macro TREES_LANES_PERF_EN.
- When defined: adds output cycles_last (32 bits), the cycle count from accepted start to done for the last inference. Reset to 0. Saturates at all-ones.
- When undefined: port and counter absent; otherwise identical behaviour.

Decomposition:
- Package trees_pkg holds:
  - node_t packed struct (value/threshold, right child, feature index, leaf flag);
  - float-to-ordered compare function;
  - saturation function;
  - lane state enum.
- Sub-module trees_lane_walker: one lane's node RAM, walker FSM, partial accumulator and fault flag. Instantiated N_LANES times via generate.

Test Plan:
- Stumps: each tree is a leaf with value 1. n_trees_active=128 -> prediction=128, error=0; done at cycle 2+32*2+1 after start for N_LANES=4.
- Depth-2 trees: node0 splits on feature 3, threshold 0.5; left leaf=+10, right leaf=-7. Feature 3 = 0.25 -> prediction=1280; feature 3 = 0.75 -> -896.
- Double buffering: load sample B during sample A's RUN -> A result unaffected; second start yields B result.
- Self-loop: right child = 0 on every tree -> error=1, prediction=0, done after MAX_DEPTH visits.
- Saturation: 128 leaves of 0x7FFFFFFF -> prediction=0x7FFFFFFF. n_trees_active=0 -> prediction=0 at 3 cycles.
- Reset mid-RUN: rst_n low for 2 cycles -> busy=0, no done; a fresh start completes correctly.
